// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage and its consumers (decode/control):
// instruction width, NOP encoding, field positions and the F/D bundle type.
package fetch_stage_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  // Instruction field positions, shared with control.
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int RD_MSB     = 26;
  localparam int RD_LSB     = 22;
  localparam int RS_MSB     = 21;
  localparam int RS_LSB     = 17;
  localparam int RT_MSB     = 16;
  localparam int RT_LSB     = 12;
  localparam int SHAMT_MSB  = 11;
  localparam int SHAMT_LSB  = 7;
  localparam int ALUOP_MSB  = 6;
  localparam int ALUOP_LSB  = 2;
  localparam int IMM_MSB    = 16;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 26;
  localparam int TARGET_LSB = 0;

  typedef enum logic {
    EMPTY  = 1'b0,
    STREAM = 1'b1
  } req_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
    logic               valid;
  } fd_bundle_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

  function automatic logic [4:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_fd_latch.sv
// F/D pipeline register: flush (redirect) beats enable; a cleared bundle is a NOP bubble.
module fetch_stage_fd_latch
  import fetch_stage_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic       flush,
  input  fd_bundle_t d,
  output fd_bundle_t q
);

  fd_bundle_t bundle_d;
  fd_bundle_t bundle_q;

  // Next-value selection for the F/D bundle.
  always_comb begin
    bundle_d = bundle_q;
    if (flush) begin
      bundle_d = '{instr: NOP, pc: 32'h0000_0000, valid: 1'b0};
    end else if (en) begin
      bundle_d = d;
    end else begin
      bundle_d = bundle_q;
    end
  end

  // F/D bundle register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bundle_q <= '{instr: NOP, pc: 32'h0000_0000, valid: 1'b0};
    end else begin
      bundle_q <= bundle_d;
    end
  end

  assign q = bundle_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC sequencing against a 1-cycle synchronous imem,
// with hazard stalls and execute-resolved redirects feeding the F/D register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 12
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        fd_instr,
  output logic [31:0]        fd_pc,
  output logic [31:0]        fd_pc_plus1,
  output logic               fd_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  req_state_e  req_state_q, req_state_d;
  logic        req_valid_s;
  logic [31:0] sel_pc_s;
  fd_bundle_t  fd_in_s;
  fd_bundle_t  fd_out_s;

  // Address select: while stalled the memory re-reads the in-flight PC so rdata stays coherent.
  always_comb begin
    sel_pc_s = pc_q;
    if (redirect_valid) begin
      sel_pc_s = redirect_pc;
    end else if (stall) begin
      sel_pc_s = req_pc_q;
    end else begin
      sel_pc_s = pc_q;
    end
  end

  assign imem_addr = sel_pc_s[IMEM_AW-1:0];

  // Request-state next-state logic: any non-stalled edge leaves a read in flight.
  always_comb begin
    req_state_d = req_state_q;
    case (req_state_q)
      EMPTY:   req_state_d = (redirect_valid || !stall) ? STREAM : EMPTY;
      STREAM:  req_state_d = STREAM;
      default: req_state_d = EMPTY;
    endcase
  end

  assign req_valid_s = (req_state_q == STREAM);

  // PC and in-flight request next values.
  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect_valid) begin
      req_pc_d = redirect_pc;
      pc_d     = pc_inc(redirect_pc);
    end else if (stall) begin
      req_pc_d = req_pc_q;
      pc_d     = pc_q;
    end else begin
      req_pc_d = pc_q;
      pc_d     = pc_inc(pc_q);
    end
  end

  // PC and request state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'h0000_0000;
      req_state_q <= EMPTY;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_state_q <= req_state_d;
    end
  end

  assign fd_in_s.instr = req_valid_s ? imem_rdata : NOP;
  assign fd_in_s.pc    = req_pc_q;
  assign fd_in_s.valid = req_valid_s;

  fetch_stage_fd_latch u_fd_latch (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (!stall),
    .flush   (redirect_valid),
    .d       (fd_in_s),
    .q       (fd_out_s)
  );

  assign fd_instr    = fd_out_s.instr;
  assign fd_pc       = fd_out_s.pc;
  assign fd_valid    = fd_out_s.valid;
  assign fd_pc_plus1 = pc_inc(fd_out_s.pc);

endmodule
